pal_sync_checker: RTL and testbench
===================================

// Module: pal_sync_checker
// PURPOSE
//  Downstream monitor on the 8-bit composite PAL sample stream from the pattern generator.
//  Slices sync, measures and classifies each sync pulse, checks line period, tracks field
//  structure (long/short/normal sync groups) and reports lock, line count and errors.
// PARAMETERS
//  SYNC_THRESH  38   sample < SYNC_THRESH is sync level
//  LINE_LEN     914  nominal samples per line
//  LINE_TOL     4    allowed +/- error on line period
//  SHORT_MIN/MAX 20/40   width window (samples) for short (equalising) pulse
//  NORM_MIN/MAX  48/72   width window for normal line sync
//  LONG_MIN/MAX 380/460  width window for long (broad) pulse
//  VSYNC_LONG_MIN 5  long pulses needed before short pulses count as field sync
// PORTS
//  pclk         in   1   sample clock
//  rst_n        in   1   asynchronous active-low reset
//  sample_in    in   8   composite sample, one per pclk
//  pulse_valid  out  1   1-cycle strobe: pulse_type/pulse_width valid
//  pulse_type   out  2   0 SHORT, 1 NORMAL, 2 LONG, 3 BAD
//  pulse_width  out  10  measured low duration in samples (saturates 1023)
//  field_start  out  1   1-cycle strobe on first NORMAL pulse after field sync
//  line_count   out  9   NORMAL pulses counted since field_start (saturates 511)
//  field_lines  out  9   line_count latched at end of previous field
//  locked       out  1   field structure currently recognised
//  line_err     out  1   1-cycle strobe: NORMAL-to-NORMAL period out of tolerance
// BEHAVIOUR
//  Reset: all outputs 0; FSM HUNT; counters 0; below_d = 0 (treated as above threshold).
//  Stage 1: sample_in registered; below = q < SYNC_THRESH; below_d = below delayed 1.
//  fall = below & ~below_d; rise = ~below & below_d.
//  Width ctr: load 1 on fall, +1 each cycle while below, saturate 1023.
//  On rise: next cycle pulse_valid=1, pulse_width=ctr, type by windows (inclusive); no match -> BAD.
//  Period ctr: +1 every cycle (sat 2047); on fall latch into fall_period, reload 1.
//  line_err: on NORMAL pulse whose previous classified pulse was NORMAL and
//   fall_period outside [LINE_LEN-LINE_TOL, LINE_LEN+LINE_TOL]; strobe with pulse_valid.
//  FSM, evaluated only on pulse_valid (type t):
//   HUNT:   LONG -> VSYNC, long_cnt=1; else stay.
//   VSYNC:  LONG -> long_cnt+1; SHORT -> EQ if long_cnt>=VSYNC_LONG_MIN else HUNT;
//           NORMAL/BAD -> HUNT.
//   EQ:     SHORT stay; NORMAL -> ACTIVE, field_start=1, line_count=1, locked=1;
//           LONG/BAD -> HUNT.
//   ACTIVE: NORMAL -> line_count+1; SHORT -> POSTEQ; LONG/BAD -> HUNT.
//   POSTEQ: SHORT stay; LONG -> VSYNC, long_cnt=1, field_lines=line_count; NORMAL/BAD -> HUNT.
//  Entry to HUNT clears locked and line_count; field_lines holds.
//  Timeout: period ctr reaches 2*LINE_LEN with no fall -> HUNT (stuck-high or stuck-low input).
//  Stuck low: width saturates at 1023, no pulse_valid until rise; then classified BAD.
//  fall and pulse_valid can coincide (pulse 1 sample apart): both handled, no event lost.
//  Latency: pulse_valid 2 cycles after first above-threshold sample at sample_in.
// STRUCTURE
//  pal_pkg: pulse_type enum (SHORT/NORMAL/LONG/BAD), FSM state enum, width constants.
//  Sub-module pal_pulse_classifier: slicer, edge detect, width ctr, window compare;
//   outputs pulse_valid/type/width and fall strobe. Top holds period ctr, FSM, counters.
// TESTING
//  1 Single low run of 58 samples at 0, rest at 77 -> one pulse_valid, type NORMAL, width 58.
//  2 Glitch: 3 samples at 0 -> type BAD, width 3; FSM stays HUNT, locked 0.
//  3 Full 312-line field model (7 long, short eq, 305 normal lines, short eq) repeated twice
//    -> field_start once per field, locked 1 after first, field_lines=305 at 2nd long group.
//  4 Normal lines period 914 then one line of 920 -> exactly one line_err; 917 -> none.
//  5 Input held at 77 for 2000 cycles while locked -> HUNT, locked 0, line_count 0.
//  6 rst_n low mid-field for 1 cycle -> all outputs 0 immediately; relock at next field.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared types and constants for the PAL composite sync checker.
// Pulse-width windows are inclusive and measured in samples.
package pal_pkg;

    localparam int WIDTH_W  = 10;
    localparam int PERIOD_W = 11;
    localparam int COUNT_W  = 9;

    typedef enum logic [1:0] {
        PT_SHORT  = 2'd0,
        PT_NORMAL = 2'd1,
        PT_LONG   = 2'd2,
        PT_BAD    = 2'd3
    } pulse_type_t;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_EQ     = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_POSTEQ = 3'd4
    } sync_state_t;

    localparam logic [WIDTH_W-1:0] SHORT_MIN = 10'd20;
    localparam logic [WIDTH_W-1:0] SHORT_MAX = 10'd40;
    localparam logic [WIDTH_W-1:0] NORM_MIN  = 10'd48;
    localparam logic [WIDTH_W-1:0] NORM_MAX  = 10'd72;
    localparam logic [WIDTH_W-1:0] LONG_MIN  = 10'd380;
    localparam logic [WIDTH_W-1:0] LONG_MAX  = 10'd460;

    function automatic pulse_type_t classify(input logic [WIDTH_W-1:0] w);
        if (w >= SHORT_MIN && w <= SHORT_MAX) return PT_SHORT;
        if (w >= NORM_MIN  && w <= NORM_MAX)  return PT_NORMAL;
        if (w >= LONG_MIN  && w <= LONG_MAX)  return PT_LONG;
        return PT_BAD;
    endfunction

endpackage

// File: rtl/pal_sync_checker_if.sv
// Sample stream in and checker status out; the checker is the slave,
// whoever supplies samples and consumes status is the master.
interface pal_sync_checker_if;
    import pal_pkg::*;

    logic [7:0]         sample_in;
    logic               pulse_valid;
    pulse_type_t        pulse_type;
    logic [WIDTH_W-1:0] pulse_width;
    logic               field_start;
    logic [COUNT_W-1:0] line_count;
    logic [COUNT_W-1:0] field_lines;
    logic               locked;
    logic               line_err;

    modport master (
        output sample_in,
        input  pulse_valid, pulse_type, pulse_width, field_start,
        input  line_count, field_lines, locked, line_err
    );

    modport slave (
        input  sample_in,
        output pulse_valid, pulse_type, pulse_width, field_start,
        output line_count, field_lines, locked, line_err
    );

endinterface

// File: rtl/pal_pulse_classifier.sv
// Sync slicer: registers the sample, detects low runs and reports each
// completed pulse with its width and window classification.
module pal_pulse_classifier
    import pal_pkg::*;
#(
    parameter logic [7:0] SYNC_THRESH = 8'd38
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic [7:0]         sample_in,
    output logic               fall,
    output logic               pulse_valid,
    output pulse_type_t        pulse_type,
    output logic [WIDTH_W-1:0] pulse_width
);

    logic [7:0]         sample_q;
    logic               below;
    logic               below_d;
    logic               rise;
    logic [WIDTH_W-1:0] width_ctr;

    assign below = sample_q < SYNC_THRESH;
    assign fall  = below & ~below_d;
    assign rise  = ~below & below_d;

    // sample_q resets high so the first sample after reset cannot fake a falling edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q    <= '1;
            below_d     <= 1'b0;
            width_ctr   <= '0;
            pulse_valid <= 1'b0;
            pulse_type  <= PT_SHORT;
            pulse_width <= '0;
        end else begin
            sample_q    <= sample_in;
            below_d     <= below;
            pulse_valid <= rise;
            if (fall) begin
                width_ctr <= 10'd1;
            end else if (below && width_ctr != '1) begin
                width_ctr <= width_ctr + 1'b1;
            end
            if (rise) begin
                pulse_type  <= classify(width_ctr);
                pulse_width <= width_ctr;
            end
        end
    end

endmodule

// File: rtl/pal_sync_checker.sv
// PAL sync checker top: line-period timing, field-structure FSM and status.
//   state     | meaning
//   ST_HUNT   | no structure recognised, waiting for a broad pulse
//   ST_VSYNC  | inside the broad-pulse group, counting long pulses
//   ST_EQ     | pre-equalising short pulses after a valid broad group
//   ST_ACTIVE | active lines, counting normal line syncs
//   ST_POSTEQ | post-equalising short pulses at end of field
module pal_sync_checker
    import pal_pkg::*;
#(
    parameter logic [7:0] SYNC_THRESH    = 8'd38,
    parameter int         LINE_LEN       = 914,
    parameter int         LINE_TOL       = 4,
    parameter int         VSYNC_LONG_MIN = 5
) (
    input  logic                pclk,
    input  logic                rst_n,
    pal_sync_checker_if.slave   bus
);

    localparam logic [PERIOD_W-1:0] PERIOD_LO = PERIOD_W'(LINE_LEN - LINE_TOL);
    localparam logic [PERIOD_W-1:0] PERIOD_HI = PERIOD_W'(LINE_LEN + LINE_TOL);
    localparam logic [PERIOD_W-1:0] TIMEOUT   = PERIOD_W'(2 * LINE_LEN);
    localparam logic [3:0]          VSYNC_MIN = 4'(VSYNC_LONG_MIN);

    logic                fall;
    logic                pv;
    pulse_type_t         ptype;
    logic [WIDTH_W-1:0]  pwidth;
    logic [PERIOD_W-1:0] period_ctr;
    logic [PERIOD_W-1:0] fall_period;
    logic                prev_normal;
    logic                timeout;
    logic                go_hunt;
    sync_state_t         state;
    logic [3:0]          long_cnt;
    logic [COUNT_W-1:0]  line_count;
    logic [COUNT_W-1:0]  field_lines;
    logic                locked;
    logic                field_start;

    pal_pulse_classifier #(.SYNC_THRESH(SYNC_THRESH)) u_classifier (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .sample_in   (bus.sample_in),
        .fall        (fall),
        .pulse_valid (pv),
        .pulse_type  (ptype),
        .pulse_width (pwidth)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            period_ctr  <= '0;
            fall_period <= '0;
            prev_normal <= 1'b0;
        end else begin
            if (fall) begin
                fall_period <= period_ctr;
                period_ctr  <= 11'd1;
            end else if (period_ctr != '1) begin
                period_ctr <= period_ctr + 1'b1;
            end
            if (pv) prev_normal <= (ptype == PT_NORMAL);
        end
    end

    assign timeout = period_ctr >= TIMEOUT;

    // Every transition that abandons the field structure funnels through go_hunt
    always_comb begin
        go_hunt = 1'b0;
        if (pv) begin
            case (state)
                ST_VSYNC:  go_hunt = (ptype == PT_NORMAL) || (ptype == PT_BAD) ||
                                     (ptype == PT_SHORT && long_cnt < VSYNC_MIN);
                ST_EQ,
                ST_ACTIVE: go_hunt = (ptype == PT_LONG) || (ptype == PT_BAD);
                ST_POSTEQ: go_hunt = (ptype == PT_NORMAL) || (ptype == PT_BAD);
                default:   go_hunt = 1'b0;
            endcase
        end
        go_hunt = go_hunt | timeout;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            long_cnt    <= '0;
            line_count  <= '0;
            field_lines <= '0;
            locked      <= 1'b0;
            field_start <= 1'b0;
        end else begin
            field_start <= 1'b0;
            if (go_hunt) begin
                state      <= ST_HUNT;
                long_cnt   <= '0;
                line_count <= '0;
                locked     <= 1'b0;
            end else if (pv) begin
                case (state)
                    ST_HUNT: begin
                        if (ptype == PT_LONG) begin
                            state    <= ST_VSYNC;
                            long_cnt <= 4'd1;
                        end
                    end
                    ST_VSYNC: begin
                        if (ptype == PT_LONG) begin
                            if (long_cnt != '1) long_cnt <= long_cnt + 1'b1;
                        end else if (ptype == PT_SHORT) begin
                            state <= ST_EQ;
                        end
                    end
                    ST_EQ: begin
                        if (ptype == PT_NORMAL) begin
                            state       <= ST_ACTIVE;
                            field_start <= 1'b1;
                            line_count  <= 9'd1;
                            locked      <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (ptype == PT_NORMAL) begin
                            if (line_count != '1) line_count <= line_count + 1'b1;
                        end else if (ptype == PT_SHORT) begin
                            state <= ST_POSTEQ;
                        end
                    end
                    ST_POSTEQ: begin
                        if (ptype == PT_LONG) begin
                            state       <= ST_VSYNC;
                            long_cnt    <= 4'd1;
                            field_lines <= line_count;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

    assign bus.pulse_valid = pv;
    assign bus.pulse_type  = ptype;
    assign bus.pulse_width = pwidth;
    assign bus.line_err    = pv && (ptype == PT_NORMAL) && prev_normal &&
                             (fall_period < PERIOD_LO || fall_period > PERIOD_HI);
    assign bus.field_start = field_start;
    assign bus.line_count  = line_count;
    assign bus.field_lines = field_lines;
    assign bus.locked      = locked;

endmodule

// File: tb/tb_pal_sync_checker.sv
// Scoreboard bench for pal_sync_checker: directed pulse trains, expected
// pulse records queued at issue and compared by a negedge monitor.
module tb_pal_sync_checker;
    import pal_pkg::*;

    typedef struct packed {
        pulse_type_t  ptype;
        logic [9:0]   width;
        logic         lerr;
    } exp_t;

    logic pclk = 1'b0;
    logic rst_n;

    always #5 pclk = ~pclk;

    pal_sync_checker_if bus();

    pal_sync_checker dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t e_pop;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   samp_idx  = 0;
    int   last_fall = -100000;
    bit   prev_norm = 1'b0;
    int   fs_cnt    = 0;
    int   le_cnt    = 0;
    int   le_before;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            bus.sample_in = v;
            samp_idx++;
        end
    endtask

    // Low run of w samples at level 0, then high until the next fall at 'period'
    task automatic pulse(input int w, input int period, input pulse_type_t t);
        int   fall_at;
        int   gap;
        exp_t e;
        fall_at = samp_idx + 1;
        gap     = fall_at - last_fall;
        e.ptype = t;
        e.width = (w > 1023) ? 10'd1023 : 10'(w);
        e.lerr  = (t == PT_NORMAL) && prev_norm && (gap < 910 || gap > 918);
        exp_q.push_back(e);
        prev_norm = (t == PT_NORMAL);
        last_fall = fall_at;
        drive(8'd0, w);
        drive(8'd77, period - w);
    endtask

    task automatic sync_group();
        repeat (7) pulse(420, 457, PT_LONG);
        repeat (5) pulse(30, 57, PT_SHORT);
    endtask

    task automatic post_eq();
        repeat (5) pulse(30, 57, PT_SHORT);
    endtask

    always @(negedge pclk) begin
        if (rst_n === 1'b1) begin
            if (bus.field_start) fs_cnt++;
            if (bus.line_err) le_cnt++;
            if (bus.pulse_valid) begin
                check("pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e_pop = exp_q.pop_front();
                    check("pulse_type", int'(bus.pulse_type), int'(e_pop.ptype));
                    check("pulse_width", int'(bus.pulse_width), int'(e_pop.width));
                    check("line_err", int'(bus.line_err), int'(e_pop.lerr));
                end
            end
        end
    end

    initial begin
        int lines[8] = '{914, 914, 914, 920, 914, 917, 910, 914};

        rst_n         = 1'b0;
        bus.sample_in = 8'd77;
        repeat (3) @(negedge pclk);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_line_count", int'(bus.line_count), 0);
        check("rst_field_lines", int'(bus.field_lines), 0);
        check("rst_pulse_valid", int'(bus.pulse_valid), 0);
        rst_n = 1'b1;
        drive(8'd77, 20);

        // single normal-width pulse, then a glitch and a stuck-low run
        pulse(58, 200, PT_NORMAL);
        check("t1_locked", int'(bus.locked), 0);
        pulse(3, 50, PT_BAD);
        check("t2_locked", int'(bus.locked), 0);
        check("t2_line_count", int'(bus.line_count), 0);
        pulse(1100, 1150, PT_BAD);
        check("stuck_low_locked", int'(bus.locked), 0);

        // field 1
        sync_group();
        repeat (305) pulse(58, 70, PT_NORMAL);
        post_eq();
        check("f1_locked", int'(bus.locked), 1);
        check("f1_line_count", int'(bus.line_count), 305);
        check("f1_field_start", fs_cnt, 1);
        check("f1_field_lines", int'(bus.field_lines), 0);

        // field 2
        sync_group();
        check("f2_field_lines", int'(bus.field_lines), 305);
        check("f2_locked_in_vsync", int'(bus.locked), 1);
        repeat (305) pulse(58, 70, PT_NORMAL);
        post_eq();
        check("f2_line_count", int'(bus.line_count), 305);
        check("f2_field_start", fs_cnt, 2);

        // field 3 with nominal line periods and one out-of-tolerance line
        sync_group();
        check("f3_field_lines", int'(bus.field_lines), 305);
        le_before = le_cnt;
        foreach (lines[i]) pulse(58, lines[i], PT_NORMAL);
        check("t4_line_err_count", le_cnt - le_before, 1);
        check("t4_line_count", int'(bus.line_count), 8);
        check("t4_field_start", fs_cnt, 3);

        // input stuck above threshold
        drive(8'd77, 2000);
        check("t5_locked", int'(bus.locked), 0);
        check("t5_line_count", int'(bus.line_count), 0);
        check("t5_field_lines", int'(bus.field_lines), 305);

        // short field, then a one-cycle reset mid-field, then relock
        sync_group();
        repeat (10) pulse(58, 70, PT_NORMAL);
        check("t6_pre_locked", int'(bus.locked), 1);
        check("t6_pre_line_count", int'(bus.line_count), 10);
        @(negedge pclk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_locked", int'(bus.locked), 0);
        check("t6_rst_line_count", int'(bus.line_count), 0);
        check("t6_rst_field_lines", int'(bus.field_lines), 0);
        check("t6_rst_pulse_valid", int'(bus.pulse_valid), 0);
        check("t6_rst_pulse_width", int'(bus.pulse_width), 0);
        check("t6_rst_pulse_type", int'(bus.pulse_type), 0);
        check("t6_rst_line_err", int'(bus.line_err), 0);
        check("t6_rst_field_start", int'(bus.field_start), 0);
        @(negedge pclk);
        rst_n     = 1'b1;
        prev_norm = 1'b0;
        drive(8'd77, 30);
        sync_group();
        repeat (10) pulse(58, 70, PT_NORMAL);
        check("t6_relock", int'(bus.locked), 1);
        check("t6_relock_line_count", int'(bus.line_count), 10);
        check("t6_relock_field_lines", int'(bus.field_lines), 0);
        check("t6_field_start", fs_cnt, 5);

        drive(8'd77, 20);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
